// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Default datapath widths; must match the shared alu_8bit
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 3;

  // Requester indices
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One-hot encoding of a requester index onto a 2-bit channel vector
  function automatic logic [1:0] req_onehot(input logic idx);
    return (idx == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant selection, purely combinational.
// When both requesters are valid the one named by rr_ptr wins.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the single active requester, or rr_ptr on contention
  always_comb begin
    grant_valid = |req_valid;
    grant_idx   = REQ0;
    case (req_valid)
      2'b01:   grant_idx = REQ0;
      2'b10:   grant_idx = REQ1;
      2'b11:   grant_idx = rr_ptr;
      default: grant_idx = REQ0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Operands are held stable for ALU_LAT cycles, then result/carry are
// captured into a response register and offered back to the winner.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int ALU_LAT = 1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              busy,
  output logic [7:0]        op_count
);

  // Settle counter is wide enough for the full 1..15 latency range
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(ALU_LAT - 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              grant;
  logic              rr_ptr;
  logic [CNT_W-1:0]  settle_cnt;
  logic              arb_valid;
  logic              arb_idx;
  logic              handshake;
  logic              exec_done;
  logic              rsp_done;

  rr_arb2 u_rr_arb2 (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // rst_n gates the handshake so req_ready stays low while reset is held
  assign handshake = (state == IDLE) && arb_valid && rst_n;
  assign exec_done = (state == EXEC) && (settle_cnt == '0);
  assign rsp_done  = (state == RESP) && rsp_ready[grant];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: accept, settle, then wait for the response to drain
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = EXEC;
      EXEC:    if (exec_done) next_state = RESP;
      RESP:    if (rsp_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant, priority pointer, settle counter and completed-op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= REQ0;
      rr_ptr     <= REQ0;
      settle_cnt <= '0;
      op_count   <= '0;
    end else begin
      if (handshake) begin
        grant      <= arb_idx;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == EXEC) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (rsp_done) begin
        op_count <= op_count + 8'd1;
        rr_ptr   <= ~grant;
      end
    end
  end

  // Operand latch on handshake and result capture at the end of settling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
    end else begin
      if (handshake) begin
        if (arb_idx == REQ1) begin
          alu_a   <= req1_a;
          alu_b   <= req1_b;
          alu_sel <= req1_sel;
        end else begin
          alu_a   <= req0_a;
          alu_b   <= req0_b;
          alu_sel <= req0_sel;
        end
      end
      if (exec_done) begin
        rsp_data <= alu_result;
        rsp_cout <= alu_cout;
      end
    end
  end

  // Handshake and status outputs derived from the current state
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (handshake)      req_ready = req_onehot(arb_idx);
    if (state == RESP)  rsp_valid = req_onehot(grant);
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter. Two instances are used:
// one with a single-cycle settle time, one with ALU_LAT=4 whose ALU result
// is driven directly by the bench to probe the capture point.
module tb_alu_arbiter;

  localparam int DW   = 8;
  localparam int SW   = 3;
  localparam int LAT1 = 1;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [SW-1:0] req0_sel, req1_sel, alu_sel;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_result;
  logic          rsp_cout, alu_cout, busy;
  logic [7:0]    op_count;

  logic [1:0]    d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready;
  logic [SW-1:0] d4_req0_sel, d4_req1_sel, d4_alu_sel;
  logic [DW-1:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b, d4_rsp_data;
  logic [DW-1:0] d4_alu_a, d4_alu_b, d4_alu_result;
  logic          d4_rsp_cout, d4_alu_cout, d4_busy;
  logic [7:0]    d4_op_count;

  int errCount = 0;
  int checkCount = 0;
  int mdlRr = 0;
  int mdlCount = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}
  function automatic logic [8:0] aluModel(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0: return 9'(a) + 9'(b);
      3'd1: return {a < b, a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {a[7], a << 1};
      default: return {a[0], a >> 1};
    endcase
  endfunction

  assign {alu_cout, alu_result} = aluModel(alu_sel, alu_a, alu_b);

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .ALU_LAT(LAT1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .ALU_LAT(LAT4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req0_sel(d4_req0_sel), .req0_a(d4_req0_a), .req0_b(d4_req0_b),
    .req1_sel(d4_req1_sel), .req1_a(d4_req1_a), .req1_b(d4_req1_b),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready),
    .rsp_data(d4_rsp_data), .rsp_cout(d4_rsp_cout),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel),
    .alu_result(d4_alu_result), .alu_cout(d4_alu_cout),
    .busy(d4_busy), .op_count(d4_op_count)
  );

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fresh random operands on both request channels
  task automatic randOperands();
    req0_sel = SW'($urandom); req0_a = DW'($urandom); req0_b = DW'($urandom);
    req1_sel = SW'($urandom); req1_a = DW'($urandom); req1_b = DW'($urandom);
  endtask

  // One full transaction on the LAT1 instance: request, settle, response
  // held for 'hold' cycles with only the wrong rsp_ready bit, then drained
  task automatic applyStimulus(input logic [1:0] valid, input int hold, output int gIdx);
    int expG;
    int lat;
    logic [8:0] expVal;
    logic [DW-1:0] expA, expB;
    logic [1:0] expOne;
    logic [DW-1:0] heldData;
    @(posedge clk); #1;
    req_valid = valid;
    rsp_ready = 2'b00;
    expG = (valid == 2'b01) ? 0 : (valid == 2'b10) ? 1 : mdlRr;
    expOne = (expG == 1) ? 2'b10 : 2'b01;
    expVal = (expG == 1) ? aluModel(req1_sel, req1_a, req1_b) : aluModel(req0_sel, req0_a, req0_b);
    expA = (expG == 1) ? req1_a : req0_a;
    expB = (expG == 1) ? req1_b : req0_b;
    @(negedge clk);
    checkOutput("grant", req_ready, expOne);
    @(posedge clk); #1;
    randOperands();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        lat = k;
        break;
      end
      checkOutput("readyDuringExec", req_ready, 2'b00);
      checkOutput("aluA", alu_a, expA);
      checkOutput("aluB", alu_b, expB);
      @(posedge clk); #1;
      randOperands();
    end
    checkOutput("latency", lat, 1 + LAT1);
    checkOutput("rspValid", rsp_valid, expOne);
    checkOutput("rspData", rsp_data, expVal[7:0]);
    checkOutput("rspCout", rsp_cout, expVal[8]);
    heldData = expVal[7:0];
    rsp_ready = ~expOne;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      randOperands();
      @(negedge clk);
      checkOutput("holdValid", rsp_valid, expOne);
      checkOutput("holdData", rsp_data, heldData);
      checkOutput("holdReady", req_ready, 2'b00);
    end
    rsp_ready = expOne | (($urandom_range(0, 1) == 1) ? ~expOne : 2'b00);
    @(posedge clk); #1;
    mdlCount = (mdlCount + 1) % 256;
    mdlRr = 1 - expG;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    checkOutput("idleBusy", busy, 1'b0);
    checkOutput("idleRspValid", rsp_valid, 2'b00);
    checkOutput("opCount", op_count, mdlCount);
    gIdx = expG;
  endtask

  // Bound the whole run in case the DUT stalls somewhere unexpected
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    logic [DW-1:0] prevA, la, lb;
    logic [DW-1:0] vals [1:4];
    logic          couts [1:4];
    logic [1:0]    v;

    req_valid = 2'b11; rsp_ready = 2'b00;
    randOperands();
    d4_req_valid = 2'b00; d4_rsp_ready = 2'b00;
    d4_req0_sel = '0; d4_req0_a = '0; d4_req0_b = '0;
    d4_req1_sel = '0; d4_req1_a = '0; d4_req1_b = '0;
    d4_alu_result = '0; d4_alu_cout = 1'b0;

    // Reset held with both requesters valid
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", req_ready, 2'b00);
    checkOutput("rstRspValid", rsp_valid, 2'b00);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstOpCount", op_count, 8'd0);
    checkOutput("rstAlu", {alu_sel, alu_a, alu_b}, '0);
    checkOutput("rstRsp", {rsp_cout, rsp_data}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("firstGrant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Directed add: 200 + 100 wraps to 44 with carry
    req0_sel = 3'd0; req0_a = 8'd200; req0_b = 8'd100;
    applyStimulus(2'b01, 0, g);
    checkOutput("directedData", rsp_data, 8'd44);
    checkOutput("directedCout", rsp_cout, 1'b1);

    // Continuous contention must alternate
    for (int i = 0; i < 4; i++) begin
      randOperands();
      applyStimulus(2'b11, 0, g);
    end

    // Stalled response while the other requester waits
    randOperands();
    applyStimulus(2'b11, 5, g);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      randOperands();
      v = 2'($urandom_range(1, 3));
      applyStimulus(v, $urandom_range(0, 3), g);
    end

    // Request dropped before any clock edge sees it
    prevA = alu_a;
    @(posedge clk); #1;
    req1_a = ~prevA;
    req_valid = 2'b10;
    @(negedge clk);
    checkOutput("dropReady", req_ready, 2'b10);
    req_valid = 2'b00;
    @(posedge clk); #1;
    checkOutput("dropBusy", busy, 1'b0);
    checkOutput("dropAluA", alu_a, prevA);

    // Run the counter up to 255, then wrap it
    while (mdlCount != 255) begin
      randOperands();
      v = 2'($urandom_range(1, 3));
      applyStimulus(v, 0, g);
    end
    checkOutput("count255", op_count, 8'd255);
    randOperands();
    applyStimulus(2'b01, 0, g);
    checkOutput("countWrap", op_count, 8'd0);

    // Reset during EXEC aborts the operation
    @(posedge clk); #1;
    randOperands();
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("abortBusyBefore", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 1'b0);
    checkOutput("abortRspValid", rsp_valid, 2'b00);
    checkOutput("abortOpCount", op_count, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdlCount = 0;
    mdlRr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abortNoRsp", rsp_valid, 2'b00);
    end

    // ALU_LAT=4 instance: result changes every EXEC cycle
    @(posedge clk); #1;
    d4_req0_sel = SW'($urandom); d4_req0_a = DW'($urandom); d4_req0_b = DW'($urandom);
    la = d4_req0_a; lb = d4_req0_b;
    d4_req_valid = 2'b01;
    @(negedge clk);
    checkOutput("d4Grant", d4_req_ready, 2'b01);
    @(posedge clk); #1;
    d4_req_valid = 2'b00;
    d4_req0_a = ~la; d4_req0_b = ~lb;
    for (int k = 1; k <= LAT4; k++) begin
      vals[k] = DW'($urandom);
      couts[k] = 1'($urandom);
      d4_alu_result = vals[k];
      d4_alu_cout = couts[k];
      @(negedge clk);
      checkOutput("d4ExecValid", d4_rsp_valid, 2'b00);
      checkOutput("d4AluA", d4_alu_a, la);
      checkOutput("d4AluB", d4_alu_b, lb);
      checkOutput("d4Busy", d4_busy, 1'b1);
      @(posedge clk); #1;
    end
    d4_alu_result = ~vals[LAT4];
    d4_alu_cout = ~couts[LAT4];
    @(negedge clk);
    checkOutput("d4RspValid", d4_rsp_valid, 2'b01);
    checkOutput("d4RspData", d4_rsp_data, vals[LAT4]);
    checkOutput("d4RspCout", d4_rsp_cout, couts[LAT4]);
    d4_rsp_ready = 2'b01;
    @(posedge clk); #1;
    d4_rsp_ready = 2'b00;
    @(negedge clk);
    checkOutput("d4OpCount", d4_op_count, 8'd1);
    checkOutput("d4Idle", d4_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
